// File: rtl/register_writeback.sv
// register_writeback: single writer for the register file write port.
// Merges single-cycle ALU results with in-order load returns and tracks the
// destination of every outstanding load in a small tag FIFO. A combinational
// busy mask lets decode stall on any register with a write still pending.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU result; alu_ready = accepted this cycle
//   load_issue/load_issue_rd        load issued to cache; load_issue_ready = tag queue not full
//   load_valid/load_data            load data returning in issue order; load_ready = queue not empty
//   rd/rd_write_enable/rd_data_out  registered register file write port
//   busy                            bit r set while a write to register r is pending
//
// Optional build macro REGISTER_WRITEBACK_STATS_EN adds stat_writes and
// stat_alu_stalls (32-bit wrapping event counters).
module register_writeback #(
    parameter int unsigned AddressBitWidth = 5,
    parameter int unsigned DataBitWidth    = 32,
    parameter int unsigned LoadQueueDepth  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alu_valid,
    input  logic [AddressBitWidth-1:0]        alu_rd,
    input  logic [DataBitWidth-1:0]           alu_data,
    output logic                              alu_ready,
    input  logic                              load_issue,
    input  logic [AddressBitWidth-1:0]        load_issue_rd,
    output logic                              load_issue_ready,
    input  logic                              load_valid,
    input  logic [DataBitWidth-1:0]           load_data,
    output logic                              load_ready,
    output logic [AddressBitWidth-1:0]        rd,
    output logic                              rd_write_enable,
    output logic [DataBitWidth-1:0]           rd_data_out,
    output logic [(1<<AddressBitWidth)-1:0]   busy
`ifdef REGISTER_WRITEBACK_STATS_EN
    ,
    output logic [31:0]                       stat_writes,
    output logic [31:0]                       stat_alu_stalls
`endif
);

    localparam int unsigned NumRegs = 1 << AddressBitWidth;
    localparam int unsigned PtrW    = $clog2(LoadQueueDepth) + 1;

    logic [AddressBitWidth-1:0] tag_q [LoadQueueDepth];
    logic [PtrW-1:0]            rptr_q, rptr_d;
    logic [PtrW-1:0]            wptr_q, wptr_d;
    logic [PtrW-1:0]            count_q, count_d;

    logic [AddressBitWidth-1:0] wb_rd_q, wb_rd_d;
    logic                       wb_we_q, wb_we_d;
    logic [DataBitWidth-1:0]    wb_data_q, wb_data_d;

    logic [AddressBitWidth-1:0] head_rd;
    logic [NumRegs-1:0]         busy_c;
    logic [PtrW-1:0]            offset;
    logic                       load_acc, issue_acc, alu_acc;

    // Head lookup and busy mask; an entry is live when its distance from the
    // read pointer is below the occupancy count.
    always_comb begin
        head_rd = '0;
        busy_c  = '0;
        offset  = '0;
        for (int unsigned i = 0; i < LoadQueueDepth; i++) begin
            offset = PtrW'(i) + PtrW'(LoadQueueDepth) - rptr_q;
            if (offset >= PtrW'(LoadQueueDepth)) begin
                offset = offset - PtrW'(LoadQueueDepth);
            end
            if (PtrW'(i) == rptr_q) begin
                head_rd = tag_q[i];
            end
            if (offset < count_q) begin
                busy_c[tag_q[i]] = 1'b1;
            end
        end
        if (wb_we_q) begin
            busy_c[wb_rd_q] = 1'b1;
        end
        // x0 is never written, so it is never pending.
        busy_c[0] = 1'b0;
    end

    assign load_ready       = (count_q != '0);
    assign load_issue_ready = (count_q != PtrW'(LoadQueueDepth));
    assign load_acc         = load_valid & load_ready;
    assign issue_acc        = load_issue & load_issue_ready;
    assign alu_ready        = ~load_acc & ~busy_c[alu_rd];
    assign alu_acc          = alu_valid & alu_ready;

    // Queue pointer and occupancy next state.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (load_acc) begin
            rptr_d = (rptr_q == PtrW'(LoadQueueDepth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        if (issue_acc) begin
            wptr_d = (wptr_q == PtrW'(LoadQueueDepth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        case ({issue_acc, load_acc})
            2'b10:   count_d = count_q + PtrW'(1);
            2'b01:   count_d = count_q - PtrW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write stage next state: load return wins over ALU; x0 never strobes.
    always_comb begin
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_we_d   = 1'b0;
        if (load_acc) begin
            wb_rd_d   = head_rd;
            wb_data_d = load_data;
            wb_we_d   = (head_rd != '0);
        end else if (alu_acc) begin
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
            wb_we_d   = (alu_rd != '0);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
            for (int unsigned i = 0; i < LoadQueueDepth; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_data_q <= wb_data_d;
            for (int unsigned i = 0; i < LoadQueueDepth; i++) begin
                if (issue_acc && (wptr_q == PtrW'(i))) begin
                    tag_q[i] <= load_issue_rd;
                end
            end
        end
    end

    assign rd              = wb_rd_q;
    assign rd_write_enable = wb_we_q;
    assign rd_data_out     = wb_data_q;
    assign busy            = busy_c;

`ifdef REGISTER_WRITEBACK_STATS_EN
    logic [31:0] stat_writes_q, stat_alu_stalls_q;

    // Wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_writes_q     <= '0;
            stat_alu_stalls_q <= '0;
        end else begin
            if (wb_we_q) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
            if (alu_valid && !alu_ready) begin
                stat_alu_stalls_q <= stat_alu_stalls_q + 32'd1;
            end
        end
    end

    assign stat_writes     = stat_writes_q;
    assign stat_alu_stalls = stat_alu_stalls_q;
`endif

endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;

    localparam int A     = 5;
    localparam int D     = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [A-1:0]  alu_rd = '0;
    logic [D-1:0]  alu_data = '0;
    logic          alu_ready;
    logic          load_issue = 1'b0;
    logic [A-1:0]  load_issue_rd = '0;
    logic          load_issue_ready;
    logic          load_valid = 1'b0;
    logic [D-1:0]  load_data = '0;
    logic          load_ready;
    logic [A-1:0]  rd;
    logic          rd_write_enable;
    logic [D-1:0]  rd_data_out;
    logic [31:0]   busy;

    register_writeback #(
        .AddressBitWidth(A), .DataBitWidth(D), .LoadQueueDepth(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .load_issue(load_issue), .load_issue_rd(load_issue_rd), .load_issue_ready(load_issue_ready),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .rd(rd), .rd_write_enable(rd_write_enable), .rd_data_out(rd_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending load destinations plus one write-stage slot.
    logic [A-1:0] q[$];
    logic         m_we = 1'b0;
    logic [A-1:0] m_rd = '0;
    logic [D-1:0] m_data = '0;
    logic [D-1:0] rf [32];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) b[q[i]] = 1'b1;
        if (m_we) b[m_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        bit           la, ia, aa;
        logic [31:0]  mb;
        if (!rst_n) begin
            q.delete();
            m_we   <= 1'b0;
            m_rd   <= '0;
            m_data <= '0;
        end else begin
            mb = model_busy();
            la = load_valid && (q.size() != 0);
            ia = load_issue && (q.size() < DEPTH);
            aa = alu_valid && !la && !mb[alu_rd];
            if (rd_write_enable) rf[rd] <= rd_data_out;
            if (la) begin
                m_rd   <= q[0];
                m_data <= load_data;
                m_we   <= (q[0] != 0);
                void'(q.pop_front());
            end else if (aa) begin
                m_rd   <= alu_rd;
                m_data <= alu_data;
                m_we   <= (alu_rd != 0);
            end else begin
                m_we   <= 1'b0;
            end
            if (ia) q.push_back(load_issue_rd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [31:0] mb;
        mb = model_busy();
        chk("m_we", 32'(rd_write_enable), 32'(m_we));
        chk("m_rd", 32'(rd), 32'(m_rd));
        chk("m_data", rd_data_out, m_data);
        chk("m_busy", busy, mb);
        chk("m_load_ready", 32'(load_ready), 32'(q.size() != 0));
        chk("m_issue_ready", 32'(load_issue_ready), 32'(q.size() < DEPTH));
        chk("m_alu_ready", 32'(alu_ready),
            32'(!(load_valid && q.size() != 0) && !mb[alu_rd]));
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (rst_n) compare_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rd_write_enable), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_data", rd_data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", 32'(load_ready), 0);
        rst_n = 1'b1;
        step();

        // 1: ALU write to x5
        alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_1234;
        #1 chk("t1_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 0;
        chk("t1_we", 32'(rd_write_enable), 1);
        chk("t1_rd", 32'(rd), 5);
        chk("t1_data", rd_data_out, 32'h1234);
        chk("t1_busy5", 32'(busy[5]), 1);
        step();
        chk("t1_busy5_clear", 32'(busy[5]), 0);
        chk("t1_rf5", rf[5], 32'h1234);

        // 2: write to x0 completes but never strobes
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        #1 chk("t2_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 0;
        chk("t2_we", 32'(rd_write_enable), 0);
        chk("t2_busy", busy, 0);
        step();

        // 3: two loads return in order
        load_issue = 1; load_issue_rd = 3;
        step();
        load_issue_rd = 7;
        step();
        load_issue = 0;
        load_valid = 1; load_data = 32'hAAAA_AAAA;
        #1 chk("t3_busy37", busy, 32'h0000_0088);
        step();
        load_data = 32'hBBBB_BBBB;
        chk("t3_rd3", 32'(rd), 3);
        chk("t3_data3", rd_data_out, 32'hAAAA_AAAA);
        chk("t3_busy3_strobe", 32'(busy[3]), 1);
        step();
        load_valid = 0;
        chk("t3_rd7", 32'(rd), 7);
        chk("t3_data7", rd_data_out, 32'hBBBB_BBBB);
        chk("t3_busy3_clear", 32'(busy[3]), 0);
        chk("t3_busy7_strobe", 32'(busy[7]), 1);
        step();
        chk("t3_busy_clear", busy, 0);

        // 4: load return collides with ALU
        load_issue = 1; load_issue_rd = 2;
        step();
        load_issue = 0;
        load_valid = 1; load_data = 32'h11;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h22;
        #1 chk("t4_alu_ready", 32'(alu_ready), 0);
        step();
        load_valid = 0;
        chk("t4_rd2", 32'(rd), 2);
        chk("t4_data2", rd_data_out, 32'h11);
        step();
        alu_valid = 0;
        chk("t4_rd9", 32'(rd), 9);
        chk("t4_data9", rd_data_out, 32'h22);
        step();

        // 5: full queue refuses issue even with a same-cycle pop; WAW stall
        for (int i = 0; i < 4; i++) begin
            load_issue = 1; load_issue_rd = 5'(10 + i);
            step();
        end
        load_issue_rd = 14; load_valid = 1; load_data = 32'hC0;
        #1 chk("t5_issue_ready", 32'(load_issue_ready), 0);
        step();
        load_issue = 0;
        alu_valid = 1; alu_rd = 12; alu_data = 32'h55;
        #1 chk("t5_alu_stall", 32'(alu_ready), 0);
        for (int k = 1; k < 4; k++) begin
            load_data = 32'(32'hC0 + k);
            step();
        end
        load_valid = 0;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            if (rd_write_enable && rd == 5'd12) found = 1;
        end
        alu_valid = 0;
        chk("t5_alu_written", 32'(found), 1);
        chk("t5_alu_data", rd_data_out, 32'h55);
        chk("t5_rf12_load", rf[12], 32'hC2);
        step();
        chk("t5_busy14", 32'(busy[14]), 0);
        chk("t5_load_ready", 32'(load_ready), 0);

        // 6: reset with loads outstanding
        load_issue = 1; load_issue_rd = 4;
        step();
        load_issue_rd = 6;
        step();
        load_issue = 0;
        #1 rst_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_load_ready", 32'(load_ready), 0);
        step();
        rst_n = 1;
        load_valid = 1; load_data = 32'h99;
        step();
        load_valid = 0;
        chk("t6_no_write", 32'(rd_write_enable), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
